// File: rtl/gd_sweep_scheduler_if.sv
// gd_sweep_scheduler_if: start/done level handshake and result bus between the sweep scheduler and one Top engine
interface gd_sweep_scheduler_if;
  logic        gd_start_op;
  logic [31:0] gd_x_init;
  logic [31:0] gd_x_at_min;
  logic [63:0] gd_y_min;
  logic        gd_done_op;
  modport master(output gd_start_op, gd_x_init, input gd_x_at_min, gd_y_min, gd_done_op);
  modport slave(input gd_start_op, gd_x_init, output gd_x_at_min, gd_y_min, gd_done_op);
endinterface

// File: rtl/gd_sweep_scheduler.sv
// gd_sweep_scheduler: runs Top once per start point x_start + k*x_step and tracks the global minimum
module gd_sweep_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sweep_start,
  input  logic                abort,
  input  logic [31:0]         x_start,
  input  logic [31:0]         x_step,
  input  logic [IDX_W-1:0]    num_points,
  gd_sweep_scheduler_if.master bus,
  output logic                busy,
  output logic                point_valid,
  output logic [IDX_W-1:0]    point_idx,
  output logic [31:0]         point_x,
  output logic [63:0]         point_y,
  output logic [31:0]         best_x,
  output logic [63:0]         best_y,
  output logic [IDX_W-1:0]    best_idx,
  output logic                best_valid,
  output logic                done_pulse,
  output logic                aborted,
  output logic                timeout_err
);
  localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, WAIT_HI = 3'd2, RELEASE = 3'd3, FINISH = 3'd4;
  logic [2:0] state;
  logic [31:0] step, cnt;
  logic [IDX_W-1:0] n_lat, k;
  logic abort_pend, tmo, better;
  // cnt restarts on every state change, so it measures time spent in the current state
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign better = !best_valid || ($signed(bus.gd_y_min) < $signed(best_y));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      cnt <= '0;
      n_lat <= '0;
      k <= '0;
      abort_pend <= 1'b0;
      bus.gd_start_op <= 1'b0;
      bus.gd_x_init <= '0;
      busy <= 1'b0;
      point_valid <= 1'b0;
      point_idx <= '0;
      point_x <= '0;
      point_y <= '0;
      best_x <= '0;
      best_y <= '0;
      best_idx <= '0;
      best_valid <= 1'b0;
      done_pulse <= 1'b0;
      aborted <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      point_valid <= 1'b0;
      done_pulse <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sweep_start) begin
            step <= x_step;
            n_lat <= num_points;
            k <= '0;
            bus.gd_x_init <= x_start;
            best_x <= '0;
            best_y <= '0;
            best_idx <= '0;
            best_valid <= 1'b0;
            aborted <= 1'b0;
            timeout_err <= 1'b0;
            abort_pend <= 1'b0;
            busy <= 1'b1;
            state <= (num_points == '0) ? FINISH : LAUNCH;
          end
        end
        LAUNCH: begin
          cnt <= '0;
          abort_pend <= abort;
          bus.gd_start_op <= !abort;
          state <= abort ? RELEASE : WAIT_HI;
        end
        WAIT_HI:
          if (abort) begin
            abort_pend <= 1'b1;
            bus.gd_start_op <= 1'b0;
            cnt <= '0;
            state <= RELEASE;
          end else if (bus.gd_done_op) begin
            bus.gd_start_op <= 1'b0;
            point_valid <= 1'b1;
            point_idx <= k;
            point_x <= bus.gd_x_at_min;
            point_y <= bus.gd_y_min;
            if (better) begin
              best_x <= bus.gd_x_at_min;
              best_y <= bus.gd_y_min;
              best_idx <= k;
            end
            best_valid <= 1'b1;
            cnt <= '0;
            state <= RELEASE;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            bus.gd_start_op <= 1'b0;
            cnt <= '0;
            state <= FINISH;
          end
        RELEASE:
          if (!bus.gd_done_op) begin
            cnt <= '0;
            if (abort || abort_pend) begin
              aborted <= 1'b1;
              state <= FINISH;
            end else if (k == n_lat - 1'b1) state <= FINISH;
            else begin
              k <= k + 1'b1;
              bus.gd_x_init <= bus.gd_x_init + step;
              state <= LAUNCH;
            end
          end else if (tmo) begin
            timeout_err <= 1'b1;
            cnt <= '0;
            state <= FINISH;
          end
        FINISH: begin
          cnt <= '0;
          done_pulse <= 1'b1;
          busy <= 1'b0;
          abort_pend <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gd_sweep_scheduler.sv
// tb_gd_sweep_scheduler: Top stub plus table-driven, hand-written and randomized sweeps against a queue model
module tb_gd_sweep_scheduler;
  localparam int IW = 8;
  logic clk = 0, rst_n = 0, sweep_start = 0, abort = 0;
  logic [31:0] x_start = 0, x_step = 0;
  logic [IW-1:0] num_points = 0;
  logic busy, point_valid, best_valid, done_pulse, aborted, timeout_err;
  logic [IW-1:0] point_idx, best_idx;
  logic [31:0] point_x, best_x;
  logic [63:0] point_y, best_y;

  gd_sweep_scheduler_if bus();
  gd_sweep_scheduler #(.TIMEOUT_CYCLES(16), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .abort(abort),
    .x_start(x_start), .x_step(x_step), .num_points(num_points), .bus(bus),
    .busy(busy), .point_valid(point_valid), .point_idx(point_idx), .point_x(point_x),
    .point_y(point_y), .best_x(best_x), .best_y(best_y), .best_idx(best_idx),
    .best_valid(best_valid), .done_pulse(done_pulse), .aborted(aborted), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int lat = 5, mode = 0, sc;
  bit hang = 0;
  function automatic logic [63:0] yf(logic [31:0] x, int m);
    longint d = longint'($signed(x)) - 768;
    return m == 2 ? 64'h100 : m == 1 ? 64'(longint'(x[7:4]) - 8) : 64'((d * d) >>> 8);
  endfunction

  // Top stub: done_op rises lat cycles after start_op and falls one cycle after start_op falls
  assign bus.gd_x_at_min = bus.gd_x_init;
  assign bus.gd_y_min = yf(bus.gd_x_init, mode);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sc <= 0;
      bus.gd_done_op <= 1'b0;
    end else if (bus.gd_start_op) begin
      sc <= sc + 1;
      if (sc == lat - 1 && !hang) bus.gd_done_op <= 1'b1;
    end else begin
      sc <= 0;
      bus.gd_done_op <= 1'b0;
    end

  typedef struct { logic [IW-1:0] idx; logic [31:0] x; logic [63:0] y; } pt_t;
  pt_t got[$], exp_q[$];
  int n_done, n_start;
  always @(negedge clk) begin
    if (point_valid) got.push_back('{point_idx, point_x, point_y});
    if (done_pulse) n_done++;
    if (bus.gd_start_op) n_start++;
  end

  int total = 0, passed = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic m_bv;
  logic [IW-1:0] m_bi;
  logic [31:0] m_bx;
  logic [63:0] m_by;
  task automatic model(logic [31:0] xs, logic [31:0] st, int n, int m);
    logic [31:0] x = xs;
    exp_q.delete();
    m_bv = 0; m_bi = 0; m_bx = 0; m_by = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{IW'(i), x, yf(x, m)});
      if (!m_bv || $signed(yf(x, m)) < $signed(m_by)) begin
        m_bi = IW'(i); m_bx = x; m_by = yf(x, m);
      end
      m_bv = 1;
      x = x + st;
    end
  endtask

  task automatic start_sweep(logic [31:0] xs, logic [31:0] st, logic [IW-1:0] n);
    @(negedge clk);
    got.delete(); n_done = 0; n_start = 0;
    x_start = xs; x_step = st; num_points = n; sweep_start = 1;
    @(negedge clk);
    sweep_start = 0;
  endtask

  task automatic wait_done(int budget);
    int c = 0;
    while (!done_pulse && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 64'(done_pulse), 1);
    repeat (3) @(negedge clk);
    chk("done_count", 64'(n_done), 1);
    chk("busy_end", 64'(busy), 0);
    chk("start_op_end", 64'(bus.gd_start_op), 0);
  endtask

  task automatic cmp_points();
    chk("n_points", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk("pt_idx", 64'(got[i].idx), 64'(exp_q[i].idx));
      chk("pt_x", 64'(got[i].x), 64'(exp_q[i].x));
      chk("pt_y", got[i].y, exp_q[i].y);
    end
  endtask

  typedef struct {
    logic [31:0] xs, st; logic [IW-1:0] n; int m; int np;
    logic bv; logic [IW-1:0] bi; logic [31:0] bx; logic [63:0] by;
  } vec_t;
  vec_t tbl[7];

  task automatic run_vec(vec_t v);
    mode = v.m; lat = 5; hang = 0;
    model(v.xs, v.st, int'(v.n), v.m);
    start_sweep(v.xs, v.st, v.n);
    wait_done(400);
    cmp_points();
    chk("np_const", 64'(got.size()), 64'(v.np));
    chk("best_valid", 64'(best_valid), 64'(v.bv));
    chk("best_idx", 64'(best_idx), 64'(v.bi));
    chk("best_x", 64'(best_x), 64'(v.bx));
    chk("best_y", best_y, v.by);
    chk("aborted", 64'(aborted), 0);
    chk("timeout_err", 64'(timeout_err), 0);
  endtask

  initial begin
    tbl[0] = '{32'h0, 32'h100, 8'd10, 0, 10, 1'b1, 8'd3, 32'h300, 64'h0};
    tbl[1] = '{32'h0, 32'h100, 8'd4, 2, 4, 1'b1, 8'd0, 32'h0, 64'h100};
    tbl[2] = '{32'h1234, 32'h100, 8'd0, 0, 0, 1'b0, 8'd0, 32'h0, 64'h0};
    tbl[3] = '{32'h500, 32'h100, 8'd1, 0, 1, 1'b1, 8'd0, 32'h500, 64'h400};
    tbl[4] = '{32'h600, 32'hFFFFFF00, 8'd5, 0, 5, 1'b1, 8'd3, 32'h300, 64'h0};
    tbl[5] = '{32'h70, 32'h10, 8'd3, 1, 3, 1'b1, 8'd0, 32'h70, 64'hFFFFFFFFFFFFFFFF};
    tbl[6] = '{32'h50, 32'hFFFFFFF0, 8'd6, 1, 6, 1'b1, 8'd5, 32'h0, 64'hFFFFFFFFFFFFFFF8};

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(|{busy, point_valid, done_pulse, aborted, timeout_err, best_valid, bus.gd_start_op,
                           bus.gd_x_init, point_idx, point_x, point_y, best_x, best_y, best_idx}), 0);
    rst_n = 1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // zero-point sweep: done_pulse exactly two cycles after sweep_start, Top never started
    mode = 0;
    start_sweep(32'h400, 32'h100, 0);
    chk("np0_busy", 64'(busy), 1);
    chk("np0_done_early", 64'(done_pulse), 0);
    @(negedge clk);
    chk("np0_done", 64'(done_pulse), 1);
    chk("np0_busy_end", 64'(busy), 0);
    repeat (3) @(negedge clk);
    chk("np0_no_start", 64'(n_start), 0);
    chk("np0_best_valid", 64'(best_valid), 0);

    // abort during run 2 of 10
    mode = 0; lat = 5;
    model(32'h0, 32'h100, 2, 0);
    start_sweep(32'h0, 32'h100, 10);
    for (int c = 0; c < 500 && !(got.size() == 2 && bus.gd_start_op); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done(200);
    cmp_points();
    chk("abort_flag", 64'(aborted), 1);
    chk("abort_tmo", 64'(timeout_err), 0);
    chk("abort_best_idx", 64'(best_idx), 1);
    chk("abort_best_y", best_y, 64'h400);

    n_done = 0;
    abort = 1;
    repeat (3) @(negedge clk);
    abort = 0;
    chk("idle_abort_busy", 64'(busy), 0);
    chk("idle_abort_done", 64'(n_done), 0);
    chk("idle_abort_sticky", 64'(aborted), 1);

    // Top never answers
    hang = 1;
    start_sweep(32'h0, 32'h100, 3);
    wait_done(100);
    chk("tmo_flag", 64'(timeout_err), 1);
    chk("tmo_aborted_cleared", 64'(aborted), 0);
    chk("tmo_points", 64'(got.size()), 0);
    hang = 0;

    // asynchronous reset in the middle of WAIT_HI
    start_sweep(32'h400, 32'h100, 5);
    for (int c = 0; c < 50 && !bus.gd_start_op; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_start_op", 64'(bus.gd_start_op), 0);
    chk("rst_x_init", 64'(bus.gd_x_init), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_flags", 64'(timeout_err | best_valid | aborted), 0);
    @(negedge clk);
    rst_n = 1;
    run_vec(tbl[0]);

    for (int r = 0; r < 20; r++) begin
      logic [31:0] xs, st;
      int n;
      mode = $urandom_range(0, 1);
      lat = $urandom_range(1, 6);
      xs = 32'($urandom_range(0, 'hFFFF)) - 32'h8000;
      st = 32'($urandom_range(0, 'h3FF)) - 32'h200;
      n = $urandom_range(1, 8);
      model(xs, st, n, mode);
      start_sweep(xs, st, IW'(n));
      wait_done(400);
      cmp_points();
      chk("rnd_best_valid", 64'(best_valid), 64'(m_bv));
      chk("rnd_best_idx", 64'(best_idx), 64'(m_bi));
      chk("rnd_best_x", 64'(best_x), 64'(m_bx));
      chk("rnd_best_y", best_y, m_by);
      chk("rnd_flags", 64'(aborted | timeout_err), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
